// File: rtl/modaddsub_pipe.sv
// Multi-lane modular add/subtract, two-stage pipeline with valid/ready flow control.
// Stage 1 forms the raw sum/difference plus a correction flag per lane;
// stage 2 applies the modulus correction and drives the output beat.
module modaddsub_pipe #(
    parameter int unsigned       MWIDTH = 39,
    parameter int unsigned       LANES  = 4,
    parameter logic [MWIDTH-1:0] MOD    = 39'h40_0080_0001
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_vld,
    output logic                      o_rdy,
    input  logic                      i_mode,
    input  logic [LANES*MWIDTH-1:0]   i_din_0,
    input  logic [LANES*MWIDTH-1:0]   i_din_1,
    output logic                      o_vld,
    input  logic                      i_rdy,
    output logic [LANES*MWIDTH-1:0]   o_dout,
    output logic                      o_range_err,
    input  logic                      i_err_clr
);

    localparam int unsigned RW = MWIDTH + 1;
    localparam int unsigned BW = LANES * MWIDTH;

    logic                        s1_vld;
    logic                        s1_mode;
    logic [LANES-1:0][RW-1:0]    s1_raw;
    logic [LANES-1:0]            s1_flag;
    logic                        s2_vld;

    logic                        adv1;
    logic                        adv2;
    logic                        accept;
    logic [LANES-1:0][RW-1:0]    raw_nxt;
    logic [LANES-1:0]            flag_nxt;
    logic                        range_hit;
    logic [BW-1:0]               dout_nxt;

    // A stage may advance when it is empty or its successor is moving
    assign adv2   = ~s2_vld | i_rdy;
    assign adv1   = ~s1_vld | adv2;
    assign o_rdy  = adv1;
    assign accept = i_vld & adv1;
    assign o_vld  = s2_vld;

    // Stage 1 arithmetic: raw sum/difference, correction flag, operand range check
    always_comb begin
        raw_nxt   = '0;
        flag_nxt  = '0;
        range_hit = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (i_mode) begin
                raw_nxt[k]  = {1'b0, i_din_0[k*MWIDTH +: MWIDTH]} - {1'b0, i_din_1[k*MWIDTH +: MWIDTH]};
                flag_nxt[k] = i_din_0[k*MWIDTH +: MWIDTH] < i_din_1[k*MWIDTH +: MWIDTH];
            end else begin
                raw_nxt[k]  = {1'b0, i_din_0[k*MWIDTH +: MWIDTH]} + {1'b0, i_din_1[k*MWIDTH +: MWIDTH]};
                flag_nxt[k] = raw_nxt[k] >= {1'b0, MOD};
            end
            range_hit = range_hit
                      | (i_din_0[k*MWIDTH +: MWIDTH] >= MOD)
                      | (i_din_1[k*MWIDTH +: MWIDTH] >= MOD);
        end
    end

    // Stage 2 correction: fold the raw value back into [0, MOD)
    always_comb begin
        dout_nxt = '0;
        for (int k = 0; k < LANES; k++) begin
            if (s1_flag[k]) begin
                if (s1_mode) begin
                    dout_nxt[k*MWIDTH +: MWIDTH] = MWIDTH'(s1_raw[k] + RW'(MOD));
                end else begin
                    dout_nxt[k*MWIDTH +: MWIDTH] = MWIDTH'(s1_raw[k] - RW'(MOD));
                end
            end else begin
                dout_nxt[k*MWIDTH +: MWIDTH] = s1_raw[k][MWIDTH-1:0];
            end
        end
    end

    // Stage 1 register: valid follows advance, data loads only on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_mode <= 1'b0;
            s1_raw  <= '0;
            s1_flag <= '0;
        end else if (adv1) begin
            s1_vld <= i_vld;
            if (i_vld) begin
                s1_mode <= i_mode;
                s1_raw  <= raw_nxt;
                s1_flag <= flag_nxt;
            end
        end
    end

    // Stage 2 register: output beat, held stable while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            o_dout <= '0;
        end else if (adv2) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                o_dout <= dout_nxt;
            end
        end
    end

    // Sticky range error; a new error wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_range_err <= 1'b0;
        end else begin
            o_range_err <= (accept & range_hit) | (o_range_err & ~i_err_clr);
        end
    end

endmodule

// File: tb/tb_modaddsub_pipe.sv
// Bench for modaddsub_pipe: arithmetic reference model with a scoreboard queue,
// plus directed beats whose results are written out as literals.
module tb_modaddsub_pipe;

    localparam int unsigned    MW   = 39;
    localparam int unsigned    LN   = 4;
    localparam int unsigned    BW   = MW * LN;
    localparam longint unsigned MODV = 64'h40_0080_0001;
    localparam logic [MW-1:0]  MOD  = 39'h40_0080_0001;

    logic          clk;
    logic          rst_n;
    logic          i_vld;
    logic          o_rdy;
    logic          i_mode;
    logic [BW-1:0] i_din_0;
    logic [BW-1:0] i_din_1;
    logic          o_vld;
    logic          i_rdy;
    logic [BW-1:0] o_dout;
    logic          o_range_err;
    logic          i_err_clr;

    int total = 0;
    int bad   = 0;
    int n_out = 0;

    logic [BW-1:0] exp_q[$];
    logic          stall_chk = 1'b0;
    logic [BW-1:0] held      = '0;

    modaddsub_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_vld       (i_vld),
        .o_rdy       (o_rdy),
        .i_mode      (i_mode),
        .i_din_0     (i_din_0),
        .i_din_1     (i_din_1),
        .o_vld       (o_vld),
        .i_rdy       (i_rdy),
        .o_dout      (o_dout),
        .o_range_err (o_range_err),
        .i_err_clr   (i_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: modular result per lane from plain integer arithmetic
    function automatic logic [MW-1:0] ref_lane(input logic m, input logic [MW-1:0] a, input logic [MW-1:0] b);
        longint unsigned x, y, r;
        x = 64'(a);
        y = 64'(b);
        if (!m) begin
            r = x + y;
            if (r >= MODV) r = r - MODV;
        end else begin
            if (x < y) r = x + MODV - y;
            else       r = x - y;
        end
        return MW'(r);
    endfunction

    function automatic logic [BW-1:0] ref_beat(input logic m, input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < LN; k++) r[k*MW +: MW] = ref_lane(m, a[k*MW +: MW], b[k*MW +: MW]);
        return r;
    endfunction

    function automatic logic [BW-1:0] pk(input logic [MW-1:0] l0, input logic [MW-1:0] l1,
                                         input logic [MW-1:0] l2, input logic [MW-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [MW-1:0] rnd_op();
        longint unsigned v;
        v = {$urandom, $urandom};
        return MW'(v % MODV);
    endfunction

    // Scoreboard: every cycle, check readiness, stall stability and each output beat
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_chk = 1'b0;
        end else begin
            check("o_rdy", BW'(o_rdy), BW'(!(exp_q.size() == 2 && !i_rdy)));
            if (stall_chk && o_vld) check("stall_hold", o_dout, held);
            if (o_vld && i_rdy) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", BW'(o_vld), BW'(0));
                end else begin
                    check("stream", o_dout, exp_q.pop_front());
                    n_out++;
                end
            end
            stall_chk = o_vld && !i_rdy;
            held      = o_dout;
            if (i_vld && o_rdy) exp_q.push_back(ref_beat(i_mode, i_din_0, i_din_1));
        end
    end

    task automatic send(input logic m, input logic [BW-1:0] a, input logic [BW-1:0] b);
        int n;
        n = 0;
        i_vld = 1'b1; i_mode = m; i_din_0 = a; i_din_1 = b;
        @(negedge clk);
        while (!o_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!o_rdy) check("send_timeout", BW'(o_rdy), BW'(1));
        @(posedge clk); #1;
        i_vld = 1'b0;
    endtask

    task automatic get_out(output logic [BW-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!(o_vld && i_rdy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(o_vld && i_rdy)) check("out_timeout", BW'(o_vld), BW'(1));
        d = o_dout;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", BW'(exp_q.size()), BW'(0));
    endtask

    initial begin
        logic [BW-1:0] d;
        int n0, sent, cyc;
        logic acc;

        rst_n = 1'b0; i_vld = 1'b0; i_mode = 1'b0; i_din_0 = '0; i_din_1 = '0;
        i_rdy = 1'b1; i_err_clr = 1'b0;
        #12;
        check("rst_ovld", BW'(o_vld), BW'(0));
        check("rst_err", BW'(o_range_err), BW'(0));
        check("rst_dout", o_dout, BW'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Add with wrap on lane 0, plain add on lane 1; latency two cycles
        send(1'b0, pk(MOD - 39'd1, 39'd5, 39'd0, 39'd0), pk(39'd1, 39'd7, 39'd0, 39'd0));
        check("lat_c1", BW'(o_vld), BW'(0));
        @(posedge clk); #1;
        check("lat_c2", BW'(o_vld), BW'(1));
        check("t1_lane0", BW'(o_dout[MW-1:0]), BW'(0));
        check("t1_lane1", BW'(o_dout[2*MW-1:MW]), BW'(12));
        @(posedge clk); #1;

        // Subtract borrow, subtract equal, add of two maxima
        send(1'b1, pk(39'd0, 39'd9, 39'd0, 39'd0), pk(39'd1, 39'd9, 39'd0, 39'd0));
        get_out(d);
        check("t2_sub_borrow", d, pk(39'h40_0080_0000, 39'd0, 39'd0, 39'd0));
        send(1'b0, pk(MOD - 39'd1, 39'd0, 39'd0, MOD - 39'd1), pk(MOD - 39'd1, 39'd0, 39'd0, 39'd1));
        get_out(d);
        check("t2_add_max", d, pk(39'h40_007F_FFFF, 39'd0, 39'd0, 39'd0));

        // Back-pressure: two beats fill the pipe, third waits until i_rdy rises
        i_rdy = 1'b0;
        n0 = n_out;
        send(1'b0, pk(39'd10, 39'd0, 39'd0, 39'd0), pk(39'd20, 39'd0, 39'd0, 39'd0));
        send(1'b0, pk(39'd1, 39'd2, 39'd3, 39'd4), pk(39'd5, 39'd6, 39'd7, 39'd8));
        i_vld = 1'b1; i_mode = 1'b1;
        i_din_0 = pk(39'd100, 39'd3, 39'd0, 39'd77);
        i_din_1 = pk(39'd50, 39'd4, 39'd0, 39'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_ordy", BW'(o_rdy), BW'(0));
            check("full_ovld", BW'(o_vld), BW'(1));
            check("stall_dout", o_dout, pk(39'd30, 39'd0, 39'd0, 39'd0));
        end
        @(posedge clk); #1;
        i_rdy = 1'b1;
        #1;
        check("ordy_free", BW'(o_rdy), BW'(1));
        send(1'b1, pk(39'd100, 39'd3, 39'd0, 39'd77), pk(39'd50, 39'd4, 39'd0, 39'd7));
        send(1'b0, pk(39'd11, 39'd22, 39'd33, 39'd44), pk(39'd1, 39'd2, 39'd3, 39'd4));
        drain();
        check("bp_count", BW'(n_out - n0), BW'(4));

        // Random traffic with held-until-accepted inputs
        n0 = n_out; sent = 0; cyc = 0;
        while (sent < 10000 && cyc < 60000) begin
            if (!i_vld && $urandom_range(3) != 0) begin
                i_vld = 1'b1;
                i_mode = 1'($urandom_range(1));
                for (int k = 0; k < LN; k++) begin
                    i_din_0[k*MW +: MW] = rnd_op();
                    i_din_1[k*MW +: MW] = rnd_op();
                end
            end
            i_rdy = ($urandom_range(3) != 0);
            @(negedge clk);
            acc = i_vld && o_rdy;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                i_vld = 1'b0;
            end
            cyc++;
        end
        i_vld = 1'b0; i_rdy = 1'b1;
        drain();
        check("rand_sent", BW'(sent), BW'(10000));
        check("rand_out", BW'(n_out - n0), BW'(10000));
        check("rand_err", BW'(o_range_err), BW'(0));

        // Range error: set, sticky, clear, set-and-clear together
        send(1'b0, pk(39'd7, 39'd0, 39'd0, 39'd3), pk(39'd0, 39'd0, 39'd0, MOD));
        check("err_set", BW'(o_range_err), BW'(1));
        @(posedge clk); #1;
        check("err_sticky", BW'(o_range_err), BW'(1));
        i_err_clr = 1'b1;
        @(posedge clk); #1;
        i_err_clr = 1'b0;
        check("err_clr", BW'(o_range_err), BW'(0));
        i_err_clr = 1'b1;
        send(1'b1, pk(39'd0, 39'd0, 39'd0, MOD), pk(39'd0, 39'd0, 39'd0, 39'd1));
        i_err_clr = 1'b0;
        check("err_set_clr", BW'(o_range_err), BW'(1));
        drain();
        i_err_clr = 1'b1;
        @(posedge clk); #1;
        i_err_clr = 1'b0;
        check("err_clr2", BW'(o_range_err), BW'(0));

        // Reset with two beats in flight: nothing from before reset emerges
        send(1'b0, pk(39'd1, 39'd1, 39'd1, 39'd1), pk(39'd1, 39'd1, 39'd1, 39'd1));
        send(1'b0, pk(39'd2, 39'd2, 39'd2, 39'd2), pk(39'd2, 39'd2, 39'd2, 39'd2));
        rst_n = 1'b0;
        #1;
        check("midrst_ovld", BW'(o_vld), BW'(0));
        check("midrst_dout", o_dout, BW'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n0 = n_out;
        send(1'b0, pk(39'd0, 39'd0, 39'd1000, 39'd0), pk(39'd0, 39'd0, 39'd234, 39'd0));
        get_out(d);
        check("post_rst_first", d, pk(39'd0, 39'd0, 39'd1234, 39'd0));
        drain();
        check("post_rst_count", BW'(n_out - n0), BW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
